// File: rtl/i2c_master_tx.sv
// I2C master transmitter: pops bytes from the TX FIFO and sends them to a 7-bit
// slave as one write transaction (START, address+W, data until empty, STOP).
module i2c_master_tx #(
    parameter int unsigned data_size = 8,
    parameter int unsigned CLK_DIV   = 25
) (
    input  logic                 i2c_clk,
    input  logic                 i2c_reset_n,
    input  logic                 enable,
    input  logic [6:0]           slave_address,
    input  logic [data_size-1:0] read_data,
    input  logic                 read_empty,
    output logic                 read_increment,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 scl_oe,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 ack_error,
    output logic                 done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       quarter_q, quarter_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [6:0]       addr_q, addr_d;
    logic             ack_q, ack_d;
    logic             ack_error_d, busy_d, done_d, pop_d;
    logic             scl_oe_d, sda_oe_d;
    logic             in_ack;

    assign in_ack = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK);

    // Sequencing: quarter timing, bit counting and state decisions at the end of q3
    always_comb begin
        state_d     = state_q;
        quarter_d   = quarter_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        ack_d       = ack_q;
        ack_error_d = ack_error;
        busy_d      = busy;
        done_d      = 1'b0;
        pop_d       = 1'b0;

        if (state_q == ST_IDLE) begin
            if (enable && !read_empty) begin
                state_d     = ST_START;
                addr_d      = slave_address;
                ack_error_d = 1'b0;
                busy_d      = 1'b1;
            end
        end else if (quarter_q == 2'd1 && !scl_in) begin
            // A slave holding SCL low freezes the released quarter
            div_d = '0;
        end else if (div_q != DIV_LAST) begin
            div_d = DIV_W'(div_q + 1'b1);
        end else begin
            div_d     = '0;
            quarter_d = 2'(quarter_q + 2'd1);
            if (quarter_q == 2'd2 && in_ack) begin
                ack_d = sda_in;
            end
            if (quarter_q == 2'd3) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_ADDR;
                        shift_d = {addr_q, 1'b0};
                        bit_d   = '0;
                    end
                    ST_ADDR, ST_DATA: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = 3'(bit_q + 3'd1);
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (ack_q) begin
                            ack_error_d = 1'b1;
                            state_d     = ST_STOP;
                        end else if ((state_q == ST_ADDR_ACK || enable) && !read_empty) begin
                            state_d = ST_DATA;
                            shift_d = 8'(read_data);
                            bit_d   = '0;
                            pop_d   = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Line drive for the position being entered, so the pins are registered
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: begin
                scl_oe_d = (quarter_d == 2'd3);
                sda_oe_d = quarter_d[1];
            end
            ST_ADDR, ST_DATA: begin
                scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_oe_d = ~shift_d[7];
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
            end
            ST_STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state_q        <= ST_IDLE;
            quarter_q      <= '0;
            div_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            addr_q         <= '0;
            ack_q          <= 1'b0;
            scl_oe         <= 1'b0;
            sda_oe         <= 1'b0;
            read_increment <= 1'b0;
            busy           <= 1'b0;
            ack_error      <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            quarter_q      <= quarter_d;
            div_q          <= div_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            addr_q         <= addr_d;
            ack_q          <= ack_d;
            scl_oe         <= scl_oe_d;
            sda_oe         <= sda_oe_d;
            read_increment <= pop_d;
            busy           <= busy_d;
            ack_error      <= ack_error_d;
            done           <= done_d;
        end
    end

endmodule

// File: doc/i2c_master_tx.md
# i2c_master_tx

I2C master transmitter at the I2C end of the APB-to-I2C bridge. It pops bytes from the TX FIFO read port (`read_data`/`read_empty`/`read_increment`) and sends them to a 7-bit slave as a single I2C write transaction: START, address+W, data bytes until the FIFO drains, then STOP. SCL and SDA are driven open-drain through pull-low enables. It runs in the FIFO read-clock domain.

## Interface
- `data_size`, 8: FIFO byte width; must be 8.
- `CLK_DIV`, 25: `i2c_clk` cycles per SCL quarter-period, minimum 2; counter width is `$clog2(CLK_DIV)`.
- `i2c_clk`  in  1  block clock, which is the FIFO `read_clk` domain.
- `i2c_reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits a transaction to start; level-sensitive.
- `slave_address`  in  7  target address, latched at START.
- `read_data`  in  data_size  FIFO head byte; valid combinationally while `read_empty`=0.
- `read_empty`  in  1  FIFO empty flag.
- `read_increment`  out  1  one-cycle FIFO pop.
- `scl_in`, `sda_in`  in  1  synchronized bus line levels.
- `scl_oe`, `sda_oe`  out  1  1 pulls the line low; 0 releases it.
- `busy`  out  1  high from START entry until STOP completes.
- `ack_error`  out  1  sticky NACK flag; cleared at the next START.
- `done`  out  1  one-cycle pulse when STOP completes.

## Operation
- Reset values: `scl_oe`=0, `sda_oe`=0, `read_increment`=0, `busy`=0, `ack_error`=0, `done`=0; state IDLE; counters 0.
- Every state is 4 quarters q0..q3; each quarter lasts `CLK_DIV` cycles.
- Bit phases:
  - q0: SCL low; SDA is set.
  - q1: SCL released.
  - q2: SCL high; SDA is sampled at the last cycle of q2.
  - q3: SCL low.
- IDLE → START when `enable`=1 and `read_empty`=0. On this transition: latch `slave_address`, clear `ack_error`, set `busy`.
- START:
  - q0–q1: SDA and SCL released.
  - q2: SDA low while SCL is high.
  - q3: SCL low.
  - Then go to ADDR.
- ADDR: shift out `{slave_address,1'b0}`, MSB first, 8 bits. Then go to ADDR_ACK.
- ADDR_ACK: SDA released for 1 bit; `sda_in` is sampled in q2.
  - Sample 1 (NACK): set `ack_error`, go to STOP.
  - Sample 0 with FIFO non-empty: load byte, go to DATA.
  - Sample 0 with FIFO empty: go to STOP.
- Byte load: on the edge entering DATA, the shift register captures `read_data`. `read_increment`=1 for exactly the next cycle. `read_data` is not sampled again until the next load.
- DATA: 8 bits, MSB first. Then go to DATA_ACK.
- DATA_ACK: sampled as in ADDR_ACK.
  - NACK: set `ack_error`, go to STOP with no pop.
  - ACK, `enable`=1, FIFO non-empty: load, go to DATA.
  - Otherwise: go to STOP.
- STOP:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2: SDA released while SCL is high.
  - q3: bus idle.
  - At the end of q3: `busy`=0, `done`=1 for one cycle, go to IDLE.
- Clock stretching: in any q1, the quarter counter holds at 0 while `scl_in`=0. It applies in every state, including START and STOP.
- `enable` falling mid-transaction: the current byte and its ACK bit complete, then STOP. No byte is abandoned.
- `read_empty` is evaluated only in IDLE and at ACK decisions. Bytes written during a transaction are sent if they are present at the ACK decision.
- Asynchronous reset mid-transfer: both lines are released immediately and all state is lost. The FIFO keeps unpopped bytes.

## Timing
- IDLE → START occurs on the first edge where the start condition holds. `scl_oe`/`sda_oe` are registered outputs.
- Transaction length without stretching, for N bytes: (4 + 36 + 36·N + 4)·`CLK_DIV` cycles, measured from START entry to the `done` pulse.
- Each SCL stretch of k cycles adds exactly k cycles.
- Pops are at least 36·`CLK_DIV` cycles apart. Each pop follows its load by exactly 1 cycle.
- `done` and `busy` falling occur on the same edge. IDLE may restart on the following edge, so back-to-back transactions are allowed.

## Test plan
- Single byte, `CLK_DIV`=4, address 0x50, FIFO holds {0xA5}, slave ACKs → SDA carries 0xA0 then 0xA5; one `read_increment` pulse; `done` 320 cycles after START; `ack_error`=0.
- Address NACK: `sda_in` high in ADDR_ACK → `ack_error`=1; zero pops; STOP completes; FIFO still holds 0xA5.
- FIFO {0x11,0x22,0x33}, slave NACKs byte 0x22 → exactly 2 pops; 0x33 remains; `ack_error`=1; STOP follows the NACK bit.
- Stretching: hold `scl_in` low 10 extra cycles in q1 of address bit 3 → `done` arrives 10 cycles later than the unstretched run; bit values are unchanged.
- `enable` dropped during byte 1 of {0x01,0x02} → byte 1 completes with ACK, then STOP; 1 pop; 0x02 remains.
- Assert `i2c_reset_n`=0 mid-DATA → `scl_oe`=`sda_oe`=0 immediately; after release, state is IDLE and a new START begins when `enable`=1 and the FIFO is non-empty.
